// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: the {rob_ix, value} entry broadcast to the ROB and
// reservation stations, plus widths used by rob, RS and functional units.
package cdb_arbiter_pkg;

    localparam int CDB_ROB_IX_WIDTH = 3;
    localparam int CDB_DATA_WIDTH   = 32;
    localparam int CDB_NUM_FU       = 4;
    localparam int CDB_BUF_DEPTH    = 2;

    typedef logic [CDB_ROB_IX_WIDTH-1:0] rob_ix_t;
    typedef logic [CDB_DATA_WIDTH-1:0]   cdb_data_t;

    typedef struct packed {
        rob_ix_t   rob_ix;
        cdb_data_t value;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-side result channels and the CDB broadcast port of the arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = CDB_NUM_FU
);
    localparam int SW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic                           flush;
    logic [NUM_FU-1:0]              fu_valid;
    logic [NUM_FU-1:0][CDB_DATA_WIDTH-1:0]   fu_value;
    logic [NUM_FU-1:0][CDB_ROB_IX_WIDTH-1:0] fu_rob_ix;
    logic [NUM_FU-1:0]              fu_ready;
    logic                           cdb_valid;
    cdb_data_t                      cdb_value;
    rob_ix_t                        cdb_rob_ix;
    logic [SW-1:0]                  cdb_src;

    modport master (
        output flush, fu_valid, fu_value, fu_rob_ix,
        input  fu_ready, cdb_valid, cdb_value, cdb_rob_ix, cdb_src
    );

    modport slave (
        input  flush, fu_valid, fu_value, fu_rob_ix,
        output fu_ready, cdb_valid, cdb_value, cdb_rob_ix, cdb_src
    );

endinterface

// File: rtl/cdb_arbiter_channel_fifo.sv
// Per-channel result FIFO; the arbiter only pushes when count != DEPTH.
module cdb_arbiter_channel_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = CDB_BUF_DEPTH
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  cdb_entry_t               din,
    output cdb_entry_t               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    cdb_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: per-FU FIFOs, one broadcast per cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU    = CDB_NUM_FU,
    parameter int BUF_DEPTH = CDB_BUF_DEPTH
)(
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    localparam int SW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    cdb_entry_t        head  [NUM_FU];
    logic [CW-1:0]     count [NUM_FU];
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] empty;
    logic              found;
    logic [SW-1:0]     win;
    logic [SW-1:0]     rr_ptr;
    logic              cdb_valid;
    cdb_data_t         cdb_value;
    rob_ix_t           cdb_rob_ix;
    logic [SW-1:0]     cdb_src;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_ch
        cdb_entry_t din;
        // Ready looks only at the registered count: no push-through-pop.
        assign bus.fu_ready[i] = (count[i] != CW'(BUF_DEPTH));
        assign push[i] = bus.fu_valid[i] & bus.fu_ready[i];
        assign pop[i]  = found & (win == SW'(i)) & ~bus.flush;
        assign din     = '{rob_ix: bus.fu_rob_ix[i],
                           value:  bus.fu_value[i]};

        cdb_arbiter_channel_fifo #(
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (bus.flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (din),
            .head  (head[i]),
            .count (count[i]),
            .empty (empty[i])
        );
    end

    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid  <= 1'b0;
            cdb_value  <= '0;
            cdb_rob_ix <= '0;
            cdb_src    <= '0;
            rr_ptr     <= '0;
        end else if (bus.flush) begin
            cdb_valid  <= 1'b0;
            rr_ptr     <= '0;
        end else if (found) begin
            cdb_valid  <= 1'b1;
            cdb_value  <= head[win].value;
            cdb_rob_ix <= head[win].rob_ix;
            cdb_src    <= win;
            rr_ptr     <= (win == SW'(NUM_FU - 1)) ? '0 : win + 1'b1;
        end else begin
            cdb_valid  <= 1'b0;
        end
    end

    assign bus.cdb_valid  = cdb_valid;
    assign bus.cdb_value  = cdb_value;
    assign bus.cdb_rob_ix = cdb_rob_ix;
    assign bus.cdb_src    = cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed + random checks of cdb_arbiter against a queue-based bus model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 4;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(N)) bus ();

    cdb_arbiter #(.NUM_FU(N), .BUF_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    cdb_entry_t q [N][$];
    int         rr;
    bit         exp_valid;
    cdb_data_t  exp_value;
    rob_ix_t    exp_rob;
    int         exp_src;
    bit [N-1:0] last_acc;
    int         n_acc;
    int         n_bcast;
    int         gcnt [N];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        rr = 0;
        exp_valid = 0;
        exp_value = '0;
        exp_rob = '0;
        exp_src = 0;
    endtask

    // One bus cycle as seen by the FUs/ROB: grant from what was
    // buffered before the edge, then append this cycle's accepts.
    task automatic model_edge();
        last_acc = '0;
        if (bus.flush) begin
            for (int i = 0; i < N; i++) q[i].delete();
            rr = 0;
            exp_valid = 0;
            return;
        end
        for (int i = 0; i < N; i++)
            last_acc[i] = bus.fu_valid[i] && (q[i].size() < D);
        exp_valid = 0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (rr + k) % N;
            if (q[c].size() > 0) begin
                cdb_entry_t e;
                e = q[c].pop_front();
                exp_valid = 1;
                exp_value = e.value;
                exp_rob = e.rob_ix;
                exp_src = c;
                rr = (c + 1) % N;
                break;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (last_acc[i]) begin
                q[i].push_back('{rob_ix: bus.fu_rob_ix[i],
                                 value: bus.fu_value[i]});
                n_acc++;
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] rdy;
        for (int i = 0; i < N; i++) rdy[i] = (q[i].size() != D);
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(exp_valid));
        chk("cdb_value", 64'(bus.cdb_value), 64'(exp_value));
        chk("cdb_rob_ix", 64'(bus.cdb_rob_ix), 64'(exp_rob));
        chk("cdb_src", 64'(bus.cdb_src), 64'(exp_src));
        chk("fu_ready", 64'(bus.fu_ready), 64'(rdy));
        if (bus.cdb_valid === 1'b1) begin
            n_bcast++;
            gcnt[bus.cdb_src]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(logic [N-1:0] v);
        bus.fu_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.fu_value[i] = $urandom();
            bus.fu_rob_ix[i] = rob_ix_t'($urandom_range(0, 7));
        end
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    initial begin
        int n;
        int guard;
        bus.flush = 1'b0;
        drive('0);
        model_reset();
        n_acc = 0;
        n_bcast = 0;
        foreach (gcnt[i]) gcnt[i] = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_value", 64'(bus.cdb_value), 64'd0);
        chk("rst_rob", 64'(bus.cdb_rob_ix), 64'd0);
        chk("rst_src", 64'(bus.cdb_src), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.fu_ready), 64'hF);

        // Single result from ch1
        drive(4'b0010);
        bus.fu_rob_ix[1] = 3'd5;
        bus.fu_value[1] = 32'h1234;
        step();
        chk("t1_lat", 64'(bus.cdb_valid), 64'd0);
        drive('0);
        step();
        chk("t1_valid", 64'(bus.cdb_valid), 64'd1);
        chk("t1_rob", 64'(bus.cdb_rob_ix), 64'd5);
        chk("t1_value", 64'(bus.cdb_value), 64'h1234);
        chk("t1_src", 64'(bus.cdb_src), 64'd1);
        step();
        chk("t1_drop", 64'(bus.cdb_valid), 64'd0);

        // Contention from rr_ptr=0, then ch2 alone
        do_flush();
        drive(4'b1111);
        for (int i = 0; i < N; i++) bus.fu_rob_ix[i] = rob_ix_t'(i);
        step();
        drive('0);
        for (int i = 0; i < N; i++) begin
            step();
            chk("t2_order", 64'(bus.cdb_src), 64'(i));
        end
        drive(4'b0100);
        step();
        drive('0);
        step();
        chk("t2_ch2", 64'(bus.cdb_src), 64'd2);

        // Fairness ch0 vs ch3
        for (int c = 0; c < 16; c++) begin
            drive(4'b1001);
            step();
        end
        drive('0);
        repeat (6) step();

        // Backpressure on ch0 with the bus kept busy
        do_flush();
        n = 0;
        guard = 0;
        while (n < 3 && guard < 30) begin
            drive((guard < 3) ? 4'b1111 : 4'b0001);
            bus.fu_value[0] = 32'hA + 32'(n);
            step();
            if (last_acc[0]) n++;
            guard++;
        end
        chk("t4_accepts", 64'(n), 64'd3);
        drive('0);
        repeat (10) step();

        // Flush with a concurrent push
        drive(4'b0111);
        step();
        drive(4'b1000);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive('0);
        repeat (3) step();
        drive(4'b1001);
        step();
        drive('0);
        step();
        chk("t5_rr0", 64'(bus.cdb_src), 64'd0);
        step();

        // Async reset mid-stream
        drive(4'b1111);
        step();
        step();
        drive('0);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", 64'(bus.cdb_valid), 64'd0);
        chk("t6_value", 64'(bus.cdb_value), 64'd0);
        chk("t6_rob", 64'(bus.cdb_rob_ix), 64'd0);
        chk("t6_src", 64'(bus.cdb_src), 64'd0);
        model_reset();
        #1 rst = 1'b0;
        drive(4'b0100);
        step();
        drive('0);
        step();
        chk("t6_fresh", 64'(bus.cdb_src), 64'd2);

        // Random traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 3) == 0) ? '0 : N'($urandom()));
            bus.flush = ($urandom_range(0, 39) == 0);
            step();
        end
        bus.flush = 1'b0;

        // Saturation: equal share, nothing lost
        drive('0);
        do_flush();
        n_acc = 0;
        n_bcast = 0;
        foreach (gcnt[i]) gcnt[i] = 0;
        for (int c = 0; c < 41; c++) begin
            drive(4'b1111);
            step();
        end
        for (int i = 0; i < N; i++)
            chk("sat_share", 64'(gcnt[i]), 64'd10);
        drive('0);
        repeat (12) step();
        chk("no_loss", 64'(n_bcast), 64'(n_acc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
